// File: rtl/lpc_host.sv
// LPC host initiator: runs single-byte I/O/TPM read and write frames on LFRAME#/LAD
// and returns read data plus status on a one-cycle response strobe.
module lpc_host #(
  parameter logic [3:0]  START_NIBBLE = 4'h5,
  parameter int unsigned SYNC_TIMEOUT = 8,
  parameter int unsigned LWAIT_MAX    = 255
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  output logic        lframe_o,
  inout  wire  [3:0]  lad_bus,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wr_i,
  input  logic [15:0] req_addr_i,
  input  logic [7:0]  req_wdata_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_rdata_o,
  output logic [1:0]  rsp_status_o,
  output logic [4:0]  current_state_o
);

  localparam int unsigned CW = $clog2(LWAIT_MAX + 1);

  typedef enum logic [4:0] {
    ST_IDLE    = 5'd0,
    ST_START   = 5'd1,
    ST_CYCTYPE = 5'd2,
    ST_ADDR    = 5'd3,
    ST_WDATA   = 5'd4,
    ST_TAR1    = 5'd5,
    ST_TAR2    = 5'd6,
    ST_SYNC    = 5'd7,
    ST_RDATA   = 5'd8,
    ST_FTAR1   = 5'd9,
    ST_FTAR2   = 5'd10,
    ST_ABORT   = 5'd11
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [CW-1:0] scnt_q, scnt_d;
  logic [CW-1:0] lcnt_q, lcnt_d;
  logic          wr_q, wr_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [1:0]    status_q, status_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_rdata_q, rsp_rdata_d;
  logic [1:0]    rsp_status_q, rsp_status_d;
  logic          lframe_q, lframe_d;
  logic          lad_oe_q, lad_oe_d;
  logic [3:0]    lad_out_q, lad_out_d;
  logic          ready_q, ready_d;
  logic [3:0]    lad_in_s;

  assign lad_bus         = lad_oe_q ? lad_out_q : 4'bzzzz;
  assign lad_in_s        = lad_bus;
  assign lframe_o        = lframe_q;
  assign req_ready_o     = ready_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_rdata_o     = rsp_rdata_q;
  assign rsp_status_o    = rsp_status_q;
  assign current_state_o = state_q;

  // Frame sequencing, SYNC decode with wait/no-response counters, response generation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    scnt_d       = scnt_q;
    lcnt_d       = lcnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    status_d     = status_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_status_d = rsp_status_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          wr_d    = req_wr_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START:   state_d = ST_CYCTYPE;
      ST_CYCTYPE: begin
        cnt_d   = 2'd0;
        state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (cnt_q == 2'd3) begin
          cnt_d   = 2'd0;
          state_d = wr_q ? ST_WDATA : ST_TAR1;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_WDATA: begin
        if (cnt_q == 2'd1) begin
          state_d = ST_TAR1;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_TAR1:    state_d = ST_TAR2;
      ST_TAR2: begin
        scnt_d  = '0;
        lcnt_d  = '0;
        state_d = ST_SYNC;
      end
      ST_SYNC: begin
        // Short waits and unknown codes share one run counter; a long wait breaks that run and vice versa
        case (lad_in_s)
          4'b0000, 4'b1010: begin
            status_d = (lad_in_s == 4'b1010) ? 2'b01 : 2'b00;
            cnt_d    = 2'd0;
            state_d  = wr_q ? ST_FTAR1 : ST_RDATA;
          end
          4'b0110: begin
            scnt_d = '0;
            if (lcnt_q == CW'(LWAIT_MAX - 1)) begin
              cnt_d   = 2'd0;
              state_d = ST_ABORT;
            end else begin
              lcnt_d = lcnt_q + CW'(1);
            end
          end
          default: begin
            lcnt_d = '0;
            if (scnt_q == CW'(SYNC_TIMEOUT - 1)) begin
              cnt_d   = 2'd0;
              state_d = ST_ABORT;
            end else begin
              scnt_d = scnt_q + CW'(1);
            end
          end
        endcase
      end
      ST_RDATA: begin
        if (cnt_q == 2'd1) begin
          rdata_d[7:4] = lad_in_s;
          state_d      = ST_FTAR1;
        end else begin
          rdata_d[3:0] = lad_in_s;
          cnt_d        = cnt_q + 2'd1;
        end
      end
      ST_FTAR1:   state_d = ST_FTAR2;
      ST_FTAR2: begin
        rsp_valid_d  = 1'b1;
        rsp_status_d = status_q;
        rsp_rdata_d  = wr_q ? rsp_rdata_q : rdata_q;
        state_d      = ST_IDLE;
      end
      ST_ABORT: begin
        if (cnt_q == 2'd3) begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = 2'b10;
          rsp_rdata_d  = 8'hFF;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Bus drive values derived from the upcoming state so LFRAME#/LAD come straight from flops
  always_comb begin
    lframe_d  = 1'b1;
    lad_oe_d  = 1'b0;
    lad_out_d = 4'h0;
    ready_d   = (state_d == ST_IDLE);
    case (state_d)
      ST_START: begin
        lframe_d  = 1'b0;
        lad_oe_d  = 1'b1;
        lad_out_d = START_NIBBLE;
      end
      ST_CYCTYPE: begin
        lad_oe_d  = 1'b1;
        lad_out_d = wr_d ? 4'h2 : 4'h0;
      end
      ST_ADDR: begin
        lad_oe_d = 1'b1;
        case (cnt_d)
          2'd0:    lad_out_d = addr_q[15:12];
          2'd1:    lad_out_d = addr_q[11:8];
          2'd2:    lad_out_d = addr_q[7:4];
          default: lad_out_d = addr_q[3:0];
        endcase
      end
      ST_WDATA: begin
        lad_oe_d  = 1'b1;
        lad_out_d = cnt_d[0] ? wdata_q[7:4] : wdata_q[3:0];
      end
      ST_TAR1: begin
        lad_oe_d  = 1'b1;
        lad_out_d = 4'hF;
      end
      ST_ABORT: begin
        lframe_d  = 1'b0;
        lad_oe_d  = 1'b1;
        lad_out_d = 4'hF;
      end
      default: begin
        lframe_d  = 1'b1;
        lad_oe_d  = 1'b0;
        lad_out_d = 4'h0;
      end
    endcase
  end

  // State, request and response registers
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 2'd0;
      scnt_q       <= '0;
      lcnt_q       <= '0;
      wr_q         <= 1'b0;
      addr_q       <= 16'h0000;
      wdata_q      <= 8'h00;
      rdata_q      <= 8'h00;
      status_q     <= 2'b00;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 8'h00;
      rsp_status_q <= 2'b00;
      lframe_q     <= 1'b1;
      lad_oe_q     <= 1'b0;
      lad_out_q    <= 4'h0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      scnt_q       <= scnt_d;
      lcnt_q       <= lcnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      status_q     <= status_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
      lframe_q     <= lframe_d;
      lad_oe_q     <= lad_oe_d;
      lad_out_q    <= lad_out_d;
      ready_q      <= ready_d;
    end
  end

endmodule

// File: tb/tb_lpc_host.sv
// Bench for lpc_host: scripted LPC target, per-cycle expected bus trace built from the
// frame rules, directed corner cases plus randomized transactions.
module tb_lpc_host;

  localparam int SYNC_TO = 8;
  localparam int LW_MAX  = 255;

  logic        clk_i = 1'b0;
  logic        nrst_i;
  logic        lframe_o;
  wire  [3:0]  lad_bus;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_wr_i;
  logic [15:0] req_addr_i;
  logic [7:0]  req_wdata_i;
  logic        rsp_valid_o;
  logic [7:0]  rsp_rdata_o;
  logic [1:0]  rsp_status_o;
  logic [4:0]  current_state_o;

  logic        tgt_oe;
  logic [3:0]  tgt_val;

  assign lad_bus = tgt_oe ? tgt_val : 4'bzzzz;

  lpc_host dut (
    .clk_i           (clk_i),
    .nrst_i          (nrst_i),
    .lframe_o        (lframe_o),
    .lad_bus         (lad_bus),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_wr_i        (req_wr_i),
    .req_addr_i      (req_addr_i),
    .req_wdata_i     (req_wdata_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_rdata_o     (rsp_rdata_o),
    .rsp_status_o    (rsp_status_o),
    .current_state_o (current_state_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] exp_rdata;

  // Expected per-cycle trace of one frame: LFRAME#, host drive enable/value, target drive
  bit         q_lf[$];
  bit         q_drv[$];
  logic [3:0] q_hv[$];
  bit         q_toe[$];
  logic [3:0] q_tv[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input bit lf, input bit drv, input logic [3:0] hv,
                      input bit toe, input logic [3:0] tv);
    q_lf.push_back(lf);
    q_drv.push_back(drv);
    q_hv.push_back(hv);
    q_toe.push_back(toe);
    q_tv.push_back(tv);
  endtask

  task automatic idle(input int n);
    req_valid_i = 1'b0;
    tgt_oe      = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      check_eq("idle_rsp_valid", rsp_valid_o, 1'b0);
      check_eq("idle_lframe", lframe_o, 1'b1);
      check_eq("idle_ready", req_ready_o, 1'b1);
    end
  endtask

  // codes: target SYNC nibbles in order; once exhausted the bus floats high (1111)
  task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [7:0] wdata,
                         input logic [3:0] codes[$], input logic [7:0] rdata, input bit b2b);
    int s, l, i, outcome;
    logic [3:0] c;
    logic [1:0] exp_status;
    q_lf.delete(); q_drv.delete(); q_hv.delete(); q_toe.delete(); q_tv.delete();
    push(1'b0, 1'b1, 4'h5, 1'b0, 4'h0);
    push(1'b1, 1'b1, wr ? 4'h2 : 4'h0, 1'b0, 4'h0);
    for (int k = 0; k < 4; k++) push(1'b1, 1'b1, addr[15 - 4*k -: 4], 1'b0, 4'h0);
    if (wr) begin
      push(1'b1, 1'b1, wdata[3:0], 1'b0, 4'h0);
      push(1'b1, 1'b1, wdata[7:4], 1'b0, 4'h0);
    end
    push(1'b1, 1'b1, 4'hF, 1'b0, 4'h0);
    push(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    s = 0; l = 0; i = 0; outcome = 0;
    while (outcome == 0) begin
      c = (i < codes.size()) ? codes[i] : 4'hF;
      push(1'b1, 1'b0, 4'h0, 1'b1, c);
      i++;
      if (c == 4'h0) outcome = 1;
      else if (c == 4'hA) outcome = 2;
      else if (c == 4'h6) begin
        s = 0; l++;
        if (l == LW_MAX) outcome = 3;
      end else begin
        l = 0; s++;
        if (s == SYNC_TO) outcome = 3;
      end
    end
    if (outcome != 3) begin
      if (!wr) begin
        push(1'b1, 1'b0, 4'h0, 1'b1, rdata[3:0]);
        push(1'b1, 1'b0, 4'h0, 1'b1, rdata[7:4]);
        exp_rdata = rdata;
      end
      push(1'b1, 1'b0, 4'h0, 1'b1, 4'hF);
      push(1'b1, 1'b0, 4'h0, 1'b1, 4'hF);
      exp_status = (outcome == 1) ? 2'b00 : 2'b01;
    end else begin
      for (int k = 0; k < 4; k++) push(1'b0, 1'b1, 4'hF, 1'b0, 4'h0);
      exp_status = 2'b10;
      exp_rdata  = 8'hFF;
    end

    req_wr_i    = wr;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_valid_i = 1'b1;
    check_eq("accept_ready", req_ready_o, 1'b1);
    @(posedge clk_i); #1;
    for (int k = 0; k < q_lf.size(); k++) begin
      tgt_oe  = q_toe[k];
      tgt_val = q_tv[k];
      if (!b2b) req_valid_i = 1'b0;
      req_wr_i    = 1'($urandom);
      req_addr_i  = 16'($urandom);
      req_wdata_i = 8'($urandom);
      check_eq($sformatf("lframe_c%0d", k), lframe_o, q_lf[k]);
      if (q_drv[k]) check_eq($sformatf("lad_c%0d", k), lad_bus, q_hv[k]);
      check_eq($sformatf("rsp_early_c%0d", k), rsp_valid_o, 1'b0);
      check_eq($sformatf("busy_ready_c%0d", k), req_ready_o, 1'b0);
      @(posedge clk_i); #1;
    end
    tgt_oe = 1'b0;
    check_eq("rsp_valid", rsp_valid_o, 1'b1);
    check_eq("rsp_status", rsp_status_o, exp_status);
    check_eq("rsp_rdata", rsp_rdata_o, exp_rdata);
    check_eq("end_lframe", lframe_o, 1'b1);
  endtask

  initial begin
    logic [3:0] cq[$];
    int nw, r;
    logic [3:0] oth;
    bit b2b;
    nrst_i      = 1'b0;
    req_valid_i = 1'b0;
    req_wr_i    = 1'b0;
    req_addr_i  = 16'h0000;
    req_wdata_i = 8'h00;
    tgt_oe      = 1'b0;
    tgt_val     = 4'h0;
    exp_rdata   = 8'h00;
    #22;
    check_eq("rst_lframe", lframe_o, 1'b1);
    check_eq("rst_ready", req_ready_o, 1'b1);
    check_eq("rst_rsp_valid", rsp_valid_o, 1'b0);
    check_eq("rst_rdata", rsp_rdata_o, 8'h00);
    check_eq("rst_status", rsp_status_o, 2'b00);
    check_eq("rst_state", current_state_o, 5'd0);
    @(negedge clk_i); nrst_i = 1'b1;
    @(posedge clk_i); #1;
    idle(2);

    cq = '{4'h0};
    run_txn(1'b1, 16'h0080, 8'hA5, cq, 8'h00, 1'b0);
    idle(1);
    cq = '{4'h5, 4'h5, 4'h5, 4'h0};
    run_txn(1'b0, 16'h0C2F, 8'h00, cq, 8'hC3, 1'b0);
    idle(1);
    cq = '{};
    run_txn(1'b0, 16'h1234, 8'h00, cq, 8'h00, 1'b0);
    idle(1);
    cq = '{4'hA};
    run_txn(1'b1, 16'h00F0, 8'h3C, cq, 8'h00, 1'b0);
    idle(1);
    cq = '{4'hA};
    run_txn(1'b0, 16'h4E4E, 8'h00, cq, 8'h96, 1'b0);
    idle(1);
    cq = '{};
    for (int k = 0; k < 20; k++) cq.push_back(4'h6);
    cq.push_back(4'h0);
    run_txn(1'b0, 16'hBEEF, 8'h00, cq, 8'h5A, 1'b0);
    cq = '{4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5};
    run_txn(1'b1, 16'h0003, 8'h11, cq, 8'h00, 1'b0);

    // Reset while the host is mid-address
    req_wr_i = 1'b1; req_addr_i = 16'hDEAD; req_wdata_i = 8'h77; req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    nrst_i = 1'b0;
    #1;
    check_eq("mid_rst_lframe", lframe_o, 1'b1);
    check_eq("mid_rst_ready", req_ready_o, 1'b1);
    check_eq("mid_rst_rsp_valid", rsp_valid_o, 1'b0);
    check_eq("mid_rst_rdata", rsp_rdata_o, 8'h00);
    check_eq("mid_rst_state", current_state_o, 5'd0);
    exp_rdata = 8'h00;
    @(negedge clk_i); nrst_i = 1'b1;
    @(posedge clk_i); #1;
    idle(3);
    cq = '{4'h0};
    run_txn(1'b0, 16'h0060, 8'h00, cq, 8'h42, 1'b0);

    // Randomized traffic, some frames back-to-back with request valid held high
    for (int t = 0; t < 40; t++) begin
      cq = '{};
      nw = $urandom_range(0, 7);
      for (int k = 0; k < nw; k++) begin
        r = $urandom_range(0, 2);
        oth = 4'($urandom);
        if (oth == 4'h0 || oth == 4'h5 || oth == 4'h6 || oth == 4'hA) oth = 4'hF;
        cq.push_back(r == 0 ? 4'h5 : (r == 1 ? 4'h6 : oth));
      end
      r = $urandom_range(0, 9);
      if (r >= 2) cq.push_back((r % 2 == 0) ? 4'h0 : 4'hA);
      b2b = 1'($urandom);
      run_txn(1'($urandom), 16'($urandom), 8'($urandom), cq, 8'($urandom), b2b);
      if (!b2b) idle($urandom_range(0, 2));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
